// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad-chain configuration sequencer.
// Default pad-mode words are the housekeeping reset values for each pad.
package gpio_cfg_pkg;

   localparam int GPIO_CFG_BITS = 13;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_LOAD,
      ST_DONE
   } gpio_cfg_state_t;

   localparam logic [GPIO_CFG_BITS-1:0] GPIO_MODE_MGMT_STD_INPUT_NOPULL = 13'h0403;
   localparam logic [GPIO_CFG_BITS-1:0] GPIO_MODE_MGMT_STD_OUTPUT       = 13'h1809;
   localparam logic [GPIO_CFG_BITS-1:0] GPIO_MODE_USER_STD_INPUT_NOPULL = 13'h0402;
   localparam logic [GPIO_CFG_BITS-1:0] GPIO_MODE_USER_STD_OUTPUT       = 13'h1808;

endpackage

// File: rtl/gpio_cfg_tick.sv
// Half-period strobe: tick pulses every CLK_DIV cycles; clear restarts the count
// so the first phase after clear is a full CLK_DIV cycles long.
module gpio_cfg_tick #(
   parameter int CLK_DIV = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(2*CLK_DIV+1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(CLK_DIV-1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Shifts per-pad config words MSB-first into the mprj_io chain, pad NUM_IO-1 first,
// then pulses serial_load once; every output is a flop loaded from next-state decode.
module gpio_cfg_sequencer
   import gpio_cfg_pkg::*;
#(
   parameter int NUM_IO   = 38,
   parameter int CFG_BITS = GPIO_CFG_BITS,
   parameter int CLK_DIV  = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   output logic [$clog2(NUM_IO)-1:0] cfg_addr,
   input  logic [CFG_BITS-1:0]       cfg_rdata,
   output logic                      serial_clock,
   output logic                      serial_data,
   output logic                      serial_load,
   output logic                      busy,
   output logic                      done
);

   localparam int AW = $clog2(NUM_IO);
   localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

   gpio_cfg_state_t     state_q, state_d;
   logic [CFG_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [AW-1:0]       pad_idx_q, pad_idx_d;
   logic                load_half_q, load_half_d;

   logic [AW-1:0]       addr_q, addr_d;
   logic                sclk_q, sclk_d;
   logic                sdata_q, sdata_d;
   logic                load_q, load_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                tick;
   logic                tick_clear;

   gpio_cfg_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clock (clock),
      .reset (reset),
      .clear (tick_clear),
      .tick  (tick)
   );

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      pad_idx_d   = pad_idx_q;
      load_half_d = load_half_q;
      tick_clear  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            tick_clear = 1'b1;
            if (start) begin
               pad_idx_d = AW'(NUM_IO-1);
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            tick_clear = 1'b1;
            shift_d    = cfg_rdata;
            bit_cnt_d  = BW'(CFG_BITS-1);
            state_d    = ST_SHIFT_LO;
         end
         ST_SHIFT_LO: begin
            if (tick) begin
               state_d = ST_SHIFT_HI;
            end
         end
         ST_SHIFT_HI: begin
            if (tick) begin
               shift_d   = shift_q << 1;
               bit_cnt_d = bit_cnt_q - 1'b1;
               if (bit_cnt_q != '0) begin
                  state_d = ST_SHIFT_LO;
               end else if (pad_idx_q != '0) begin
                  pad_idx_d = pad_idx_q - 1'b1;
                  state_d   = ST_FETCH;
               end else begin
                  load_half_d = 1'b0;
                  state_d     = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            // Two tick periods: load is held as long as one full serial-clock period.
            if (tick) begin
               load_half_d = ~load_half_q;
               if (load_half_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            tick_clear = 1'b1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d  = (state_d == ST_FETCH) || (state_d == ST_SHIFT_LO) ||
                (state_d == ST_SHIFT_HI) || (state_d == ST_LOAD);
      done_d  = (state_d == ST_DONE);
      sclk_d  = (state_d == ST_SHIFT_HI);
      load_d  = (state_d == ST_LOAD);
      sdata_d = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) && shift_d[CFG_BITS-1];
      addr_d  = (state_d == ST_FETCH) ? pad_idx_d : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         pad_idx_q   <= '0;
         load_half_q <= 1'b0;
         addr_q      <= '0;
         sclk_q      <= 1'b0;
         sdata_q     <= 1'b0;
         load_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         pad_idx_q   <= pad_idx_d;
         load_half_q <= load_half_d;
         addr_q      <= addr_d;
         sclk_q      <= sclk_d;
         sdata_q     <= sdata_d;
         load_q      <= load_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cfg_addr     = addr_q;
   assign serial_clock = sclk_q;
   assign serial_data  = sdata_q;
   assign serial_load  = load_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Three sequencer configurations (4x4 div1, 4x4 div3, 38x13 div1) each driven by its own
// stimulus process; a per-instance monitor checks the pad chain against a bitstream scoreboard.
module tb_gpio_cfg_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int total   = 0;
   int bad     = 0;
   int fin_cnt = 0;

   task automatic chk(input int inst, input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL inst%0d %s: got %0d, want %0d", inst, name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int NIO = (g == 2) ? 38 : 4;
      localparam int CB  = (g == 2) ? 13 : 4;
      localparam int CD  = (g == 1) ? 3 : 1;
      localparam int LEN = NIO*(1 + 2*CB*CD) + 2*CD;

      logic                      rst = 1'b1;
      logic                      st  = 1'b0;
      logic [$clog2(NIO)-1:0]    addr;
      logic [CB-1:0]             rdata;
      logic                      sclk, sdat, load, busy, done;
      logic [CB-1:0]             mem [$];

      bit                        exp_bit_q [$];
      int                        exp_len_q [$];

      gpio_cfg_sequencer #(
         .NUM_IO   (NIO),
         .CFG_BITS (CB),
         .CLK_DIV  (CD)
      ) u_dut (
         .clock        (clock),
         .reset        (rst),
         .start        (st),
         .cfg_addr     (addr),
         .cfg_rdata    (rdata),
         .serial_clock (sclk),
         .serial_data  (sdat),
         .serial_load  (load),
         .busy         (busy),
         .done         (done)
      );

      always_comb begin
         rdata = '0;
         for (int i = 0; i < NIO; i++) begin
            if (addr == ($clog2(NIO))'(i) && i < mem.size()) rdata = mem[i];
         end
      end

      // Monitor: reference is the bitstream pad NIO-1..0, each word MSB-first.
      int   k = 0, since_edge = 0, stable_cnt = 0, busy_cnt = 0, load_cnt = 0;
      int   cur_len = 0, dones = 0;
      bit   in_seq = 1'b0;
      logic p_busy = 1'b0, p_sclk = 1'b0, p_sdat = 1'b0, p_load = 1'b0;

      always @(negedge clock) begin
         if (rst) begin
            in_seq = 1'b0;
            exp_bit_q.delete();
            exp_len_q.delete();
            busy_cnt = 0;
            load_cnt = 0;
         end else begin
            since_edge++;
            stable_cnt = (sdat == p_sdat) ? stable_cnt + 1 : 1;
            if (busy && !p_busy) begin
               chk(g, "seq_expected", exp_len_q.size() > 0, 1);
               cur_len = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : -1;
               in_seq = 1'b1;
               busy_cnt = 0;
               k = 0;
               chk(g, "fetch_addr", addr, NIO-1);
            end
            if (busy) busy_cnt++;
            if (!busy && p_busy && in_seq) begin
               chk(g, "busy_len", busy_cnt, cur_len);
               chk(g, "edge_count", k, NIO*CB);
            end
            if (sclk && !p_sclk) begin
               if (exp_bit_q.size() == 0) chk(g, "edge_expected", 0, 1);
               else chk(g, "sdata_bit", sdat, exp_bit_q.pop_front());
               chk(g, "setup", stable_cnt > CD, 1);
               if (k > 0) chk(g, "edge_spacing", since_edge, (k % CB == 0) ? 2*CD+1 : 2*CD);
               k++;
               since_edge = 0;
            end
            if (sclk && p_sclk) chk(g, "hold", sdat, p_sdat);
            if (load && !p_load) chk(g, "load_after_all_edges", in_seq && (k == NIO*CB), 1);
            if (load) load_cnt++;
            if (!load && p_load) begin
               chk(g, "load_len", load_cnt, 2*CD);
               load_cnt = 0;
            end
            if (done) begin
               chk(g, "done_after_load", {p_busy, busy, p_load, in_seq}, 4'b1011);
               dones++;
               in_seq = 1'b0;
            end else if (!busy && !in_seq) begin
               chk(g, "idle_quiet", {sclk, sdat, load, addr != 0}, 0);
            end
         end
         p_busy = busy;
         p_sclk = sclk;
         p_sdat = sdat;
         p_load = load;
      end

      task automatic randomize_words();
         for (int i = 0; i < NIO; i++) mem[i] = CB'($urandom);
      endtask

      // Called one step after a rising clock edge while the DUT is idle.
      task automatic issue();
         logic [CB-1:0] w;
         for (int p = NIO-1; p >= 0; p--) begin
            w = mem[p];
            for (int b = 0; b < CB; b++) begin
               exp_bit_q.push_back(w[CB-1]);
               w = w << 1;
            end
         end
         exp_len_q.push_back(LEN);
         st = 1'b1;
         @(posedge clock);
         #1 st = 1'b0;
         chk(g, "busy_rise", busy, 1);
      endtask

      task automatic wait_done();
         int n = 0;
         while (done !== 1'b1 && n < LEN + 20) begin
            @(posedge clock);
            #1;
            n++;
         end
         chk(g, "done_seen", done, 1);
      endtask

      task automatic run_full();
         issue();
         wait_done();
         @(posedge clock);
         #1;
      endtask

      initial begin
         int nfull = 0;
         for (int i = 0; i < NIO; i++) mem.push_back('0);
         repeat (2) @(posedge clock);
         #1 rst = 1'b0;
         chk(g, "reset_state", {busy, done, sclk, sdat, load, addr != 0}, 0);
         repeat (3) @(posedge clock);
         #1;

         // One-hot words; start re-pulsed at busy cycles 5 and LEN-1 and in the done cycle.
         for (int i = 0; i < NIO; i++) mem[i] = CB'(1 << (i % CB));
         issue();
         repeat (4) @(posedge clock);
         #1 st = 1'b1;
         @(posedge clock);
         #1 st = 1'b0;
         repeat (LEN-7) @(posedge clock);
         #1 st = 1'b1;
         @(posedge clock);
         #1 st = 1'b0;
         @(posedge clock);
         #1 chk(g, "done_cycle", done, 1);
         st = 1'b1;
         @(posedge clock);
         #1 st = 1'b0;
         nfull++;
         repeat (10) @(posedge clock);
         #1;

         for (int i = 0; i < NIO; i++) mem[i] = '1;
         run_full();
         nfull++;
         for (int i = 0; i < NIO; i++) mem[i] = '0;
         run_full();
         nfull++;

         // Reset in the 20th busy cycle: no load, outputs cleared, then a clean rerun.
         randomize_words();
         issue();
         repeat (19) @(posedge clock);
         #1 rst = 1'b1;
         @(posedge clock);
         #1 rst = 1'b0;
         chk(g, "reset_mid_run", {busy, done, sclk, sdat, load, addr != 0}, 0);
         repeat (3) @(posedge clock);
         #1;
         randomize_words();
         run_full();
         nfull++;

         // run_full issues the next start in the cycle right after done.
         for (int r = 0; r < 3; r++) begin
            randomize_words();
            issue();
            wait_done();
            @(posedge clock);
            #1;
            nfull++;
         end
         repeat (5) @(posedge clock);
         #1;
         chk(g, "done_count", dones, nfull);
         chk(g, "bits_consumed", exp_bit_q.size(), 0);
         fin_cnt++;
      end
   end

   initial begin
      int n = 0;
      while (fin_cnt < 3 && n < 60000) begin
         @(posedge clock);
         n++;
      end
      chk(9, "all_finished", fin_cnt, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gpio_cfg_sequencer.md
# gpio_cfg_sequencer

Serial configuration sequencer for the user-project GPIO pad chain (`mprj_io`). On a `start` request from the management housekeeping registers, it walks the per-pad configuration words and shifts them MSB-first into the daisy-chained pad control blocks. It drives a divided serial clock during the shift and finishes with a single load strobe. The block sits between the housekeeping register file and the pad ring, and it is the only agent that changes pad modes after power-up.

## Interface
- `NUM_IO`, 38: number of pads in the chain.
- `CFG_BITS`, 13: configuration bits per pad.
- `CLK_DIV`, 1: `clock` cycles per serial-clock half-period; must be ≥1.
- `clock`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle request to (re)configure all pads; ignored while busy.
- `cfg_addr`, out, `$clog2(NUM_IO)`: pad index being fetched.
- `cfg_rdata`, in, `CFG_BITS`: configuration word for `cfg_addr`; asynchronous read, valid in the same cycle.
- `serial_clock`, out, 1: chain shift clock; pads sample `serial_data` on its rising edge.
- `serial_data`, out, 1: chain data.
- `serial_load`, out, 1: transfers the shifted values into the pad config latches.
- `busy`, out, 1: a sequence is in progress.
- `done`, out, 1: one-cycle pulse when a sequence completes.

## Operation
- States: IDLE → FETCH → SHIFT_LO ⇄ SHIFT_HI → (FETCH | LOAD) → DONE → IDLE.
- IDLE: all outputs are low. If `start`=1, go to FETCH with `pad_idx = NUM_IO-1`.
- FETCH (1 cycle):
  - `cfg_addr = pad_idx`.
  - Capture `cfg_rdata` into the shift register.
  - Set `bit_cnt = CFG_BITS-1`.
- SHIFT_LO (`CLK_DIV` cycles):
  - `serial_clock` = 0.
  - `serial_data` = shift-register MSB, stable for the whole LO and HI phase.
- SHIFT_HI (`CLK_DIV` cycles):
  - `serial_clock` = 1.
  - On exit, shift left by one and decrement `bit_cnt`.
  - If `bit_cnt` was 0 and `pad_idx` > 0: decrement `pad_idx`, go to FETCH.
  - If `bit_cnt` was 0 and `pad_idx` = 0: go to LOAD.
  - Otherwise: go to SHIFT_LO.
- Shift order: pad `NUM_IO-1` first, pad 0 last, so that pad 0's word ends up nearest the chain input.
- LOAD (`2*CLK_DIV` cycles): `serial_load` = 1, `serial_clock` = 0, `serial_data` = 0.
- DONE (1 cycle): `done` = 1, `busy` = 0.
- `busy` is 1 in FETCH, SHIFT_LO, SHIFT_HI and LOAD.
- `start` during any non-IDLE state is dropped; it is not queued.
- `start` in the DONE cycle is also dropped.
- Reset at any point:
  - Next edge forces IDLE and all outputs to 0.
  - `serial_load` is never asserted for a partial sequence, so pads keep their previous configuration.
- Reset values:
  - `busy` = `done` = `serial_clock` = `serial_data` = `serial_load` = 0.
  - `cfg_addr` = 0.

## Timing
- `start` is sampled at edge *t*; FETCH occupies cycle *t+1*; `busy` rises at *t+1*.
- Busy length = `NUM_IO*(1+2*CFG_BITS*CLK_DIV) + 2*CLK_DIV` cycles.
  - For defaults: 38·27 + 2 = 1028.
- `done` is asserted in the cycle immediately after `busy` falls.
- Rising edges of `serial_clock` per sequence: exactly `NUM_IO*CFG_BITS`.
- Consecutive serial-clock rising edges are `2*CLK_DIV` cycles apart within a pad. Across a pad boundary, one extra FETCH cycle is inserted, with `serial_clock` low.
- Setup: `serial_data` is valid ≥`CLK_DIV` cycles before each rising `serial_clock` edge and is held ≥`CLK_DIV` cycles after it.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Division counter width: `$clog2(2*CLK_DIV+1)`.
- Bit counter width: `$clog2(CFG_BITS)`.
- `pad_idx` decrements without wrap and terminates at 0.

## Structure
- Shared package `gpio_cfg_pkg`:
  - `GPIO_CFG_BITS` = 13.
  - State enum `gpio_cfg_state_t`.
  - Default pad-mode constants, used by housekeeping reset values.
- Sub-module `gpio_cfg_tick`: half-period strobe generator, parameter `CLK_DIV`.
  - Input `clear` restarts the count.
  - Output `tick` pulses every `CLK_DIV` cycles.
  - The FSM advances phases only on `tick`.

## Test plan
- Basic shift, with `NUM_IO`=4, `CFG_BITS`=4, `CLK_DIV`=1 and words pad0..3 = 0x1, 0x2, 0x4, 0x8:
  - `start` → `serial_data` sampled at rising edges = 1000 0100 0010 0001.
  - 16 rising edges; `busy` high for exactly 38 cycles.
  - `serial_load` high 2 cycles, then `done` for 1 cycle.
- Same words with `CLK_DIV`=3:
  - Edge spacing 6 cycles, 7 across each pad boundary.
  - `busy` = 4·25 + 6 = 106 cycles.
- `start` re-pulsed at busy cycles 5 and 37, and in the DONE cycle → no second sequence; exactly one `done` pulse.
- `reset` asserted in the 20th busy cycle:
  - Next cycle all outputs are 0.
  - No `serial_load` pulse is observed.
  - A following `start` runs a complete, correct 38-cycle sequence.
- Default parameters with all words = 0x1FFF, then all words = 0x0000:
  - 494 rising edges per run.
  - `serial_data` stuck at 1, then at 0, respectively.
  - `busy` = 1028 cycles per run.
- Back-to-back: `start` issued the cycle after `done` → second sequence begins FETCH on the following cycle, with `cfg_addr` = `NUM_IO-1`.
